xpsr_ctrl: RTL and testbench

Parametrised program status register block: the successor to the APSR-only xPSR, holding APSR (NZCVQ), IPSR (exception number) and EPSR (T bit, ITSTATE). It adds:
- IT-block sequencing;
- a software MSR path;
- a hardware exception entry/return path with an internal LIFO of saved xPSR words for nested exceptions.

It sits beside the ALU and the exception controller in the core. Reads are combinational.

---
 rtl/xpsr_ctrl_if.sv | 30 +++
 rtl/xpsr_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_xpsr_ctrl.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/xpsr_ctrl_if.sv
// xpsr_ctrl_if: exception entry/return handshake between the exception
// controller (master) and the program status register block (slave).
//   exc_entry_valid/ready  : request to push the current xPSR and load IPSR
//   exc_num                : exception number, sampled on the entry handshake
//   exc_return_valid/ready : request to pop and restore the saved xPSR
interface xpsr_ctrl_if #(
    parameter int unsigned EXC_NUM_W = 9
);
    logic                 exc_entry_valid;
    logic                 exc_entry_ready;
    logic [EXC_NUM_W-1:0] exc_num;
    logic                 exc_return_valid;
    logic                 exc_return_ready;

    modport master (
        output exc_entry_valid,
        output exc_num,
        output exc_return_valid,
        input  exc_entry_ready,
        input  exc_return_ready
    );

    modport slave (
        input  exc_entry_valid,
        input  exc_num,
        input  exc_return_valid,
        output exc_entry_ready,
        output exc_return_ready
    );
endinterface

// File: rtl/xpsr_ctrl.sv
// xpsr_ctrl: program status register (APSR/IPSR/EPSR) with IT-block
// sequencing, software MSR writes and an exception entry/return path that
// keeps nested contexts in an internal LIFO.
//   clk, rst_n        : clock, async active-low reset
//   flags_in/flags_we : ALU NZCV load ({n,z,c,v})
//   q_set             : sticky saturation flag set
//   msr_en/msr_data   : software APSR write, bits [31:27] = N,Z,C,V,Q
//   it_init_en/it_init: IT instruction (firstcond:mask)
//   it_advance        : instruction inside an IT block retired
//   exc               : exception entry/return handshake (slave side)
//   read_addr/read_data: combinational view select (APSR/IPSR/EPSR/xPSR)
//   in_it_block, it_cond, stack_depth : status outputs
module xpsr_ctrl #(
    parameter  int unsigned STACK_DEPTH = 4,
    parameter  int unsigned EXC_NUM_W   = 9,
    localparam int unsigned DEPTH_W     = $clog2(STACK_DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [3:0]         flags_in,
    input  logic               flags_we,
    input  logic               q_set,
    input  logic               msr_en,
    input  logic [31:0]        msr_data,
    input  logic               it_init_en,
    input  logic [7:0]         it_init,
    input  logic               it_advance,
    xpsr_ctrl_if.slave         exc,
    input  logic [1:0]         read_addr,
    output logic [31:0]        read_data,
    output logic               in_it_block,
    output logic [3:0]         it_cond,
    output logic [DEPTH_W-1:0] stack_depth
);

    localparam int unsigned ADDR_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    // A saved context holds only the architecturally live fields, not the
    // zero padding of the 32-bit word: {apsr, t, itstate, ipsr}.
    localparam int unsigned CTX_W  = 5 + 1 + 8 + EXC_NUM_W;

    typedef enum logic [1:0] {IDLE, ENTER, RETURN} state_t;

    state_t               state;
    logic [DEPTH_W-1:0]   depth;
    logic                 entry_ready;
    logic                 return_ready;
    logic [CTX_W-1:0]     snap;
    logic [EXC_NUM_W-1:0] exc_cap;

    logic [4:0]           apsr;      // {N,Z,C,V,Q}
    logic [EXC_NUM_W-1:0] ipsr;
    logic [7:0]           itstate;
    logic                 t_bit;

    logic [4:0]           apsr_n;
    logic [EXC_NUM_W-1:0] ipsr_n;
    logic [7:0]           itstate_n;
    logic                 t_n;

    logic [CTX_W-1:0]     stack_mem [STACK_DEPTH];
    logic [CTX_W-1:0]     ctx_now;
    logic [CTX_W-1:0]     pop_ctx;
    logic                 entry_fire;
    logic                 return_fire;
    logic [31:0]          apsr_view;
    logic [31:0]          ipsr_view;
    logic [31:0]          epsr_view;
    logic                 unused_msr;

    assign unused_msr  = ^msr_data[26:0];

    assign entry_fire  = exc.exc_entry_valid & entry_ready;
    // Entry has priority when both handshakes are offered together.
    assign return_fire = exc.exc_return_valid & return_ready & ~entry_fire;

    assign exc.exc_entry_ready  = entry_ready;
    assign exc.exc_return_ready = return_ready;

    assign ctx_now = {apsr, t_bit, itstate, ipsr};
    assign pop_ctx = stack_mem[ADDR_W'(depth - DEPTH_W'(1))];

    // Handshake FSM; ready lines are registered from the next state/depth.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            depth        <= '0;
            entry_ready  <= 1'b1;
            return_ready <= 1'b0;
            snap         <= '0;
            exc_cap      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (entry_fire) begin
                        state        <= ENTER;
                        snap         <= ctx_now;
                        exc_cap      <= exc.exc_num;
                        entry_ready  <= 1'b0;
                        return_ready <= 1'b0;
                    end else if (return_fire) begin
                        state        <= RETURN;
                        entry_ready  <= 1'b0;
                        return_ready <= 1'b0;
                    end
                end
                ENTER: begin
                    state        <= IDLE;
                    depth        <= depth + DEPTH_W'(1);
                    entry_ready  <= (depth + DEPTH_W'(1)) < DEPTH_W'(STACK_DEPTH);
                    return_ready <= 1'b1;
                end
                RETURN: begin
                    state        <= IDLE;
                    depth        <= depth - DEPTH_W'(1);
                    entry_ready  <= 1'b1;
                    return_ready <= depth != DEPTH_W'(1);
                end
                default: begin
                    state        <= IDLE;
                    entry_ready  <= 1'b0;
                    return_ready <= 1'b0;
                end
            endcase
        end
    end

    // Context LIFO storage; contents are meaningless above depth.
    always_ff @(posedge clk) begin
        if (state == ENTER) begin
            stack_mem[ADDR_W'(depth)] <= snap;
        end
    end

    // Next architectural state: normal updates, then ENTER/RETURN overrides.
    always_comb begin
        apsr_n    = apsr;
        ipsr_n    = ipsr;
        itstate_n = itstate;
        t_n       = t_bit;

        if (msr_en) begin
            apsr_n = msr_data[31:27];
        end else if (flags_we) begin
            apsr_n = {flags_in, apsr[0]};
        end
        apsr_n[0] = apsr_n[0] | q_set;

        if (it_init_en) begin
            itstate_n = it_init;
        end else if (it_advance && (itstate != 8'h00)) begin
            // Last instruction of the block when the remaining mask is empty.
            if (itstate[2:0] == 3'b000) begin
                itstate_n = 8'h00;
            end else begin
                itstate_n = {itstate[7:5], itstate[3:0], 1'b0};
            end
        end

        if (state == ENTER) begin
            ipsr_n    = exc_cap;
            itstate_n = 8'h00;
        end else if (state == RETURN) begin
            {apsr_n, t_n, itstate_n, ipsr_n} = pop_ctx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            apsr    <= '0;
            ipsr    <= '0;
            itstate <= '0;
            t_bit   <= 1'b1;
        end else begin
            apsr    <= apsr_n;
            ipsr    <= ipsr_n;
            itstate <= itstate_n;
            t_bit   <= t_n;
        end
    end

    assign apsr_view = {apsr, 27'b0};
    assign ipsr_view = 32'(ipsr);
    assign epsr_view = {5'b0, itstate[1:0], t_bit, 8'b0, itstate[7:2], 10'b0};

    always_comb begin
        read_data = 32'h0;
        case (read_addr)
            2'd0:    read_data = apsr_view;
            2'd1:    read_data = ipsr_view;
            2'd2:    read_data = epsr_view;
            default: read_data = apsr_view | ipsr_view | epsr_view;
        endcase
    end

    assign in_it_block = itstate[3:0] != 4'h0;
    assign it_cond     = itstate[7:4];
    assign stack_depth = depth;

endmodule

// File: tb/tb_xpsr_ctrl.sv
// tb_xpsr_ctrl: scoreboard bench for xpsr_ctrl. The driver advances a
// word-level reference model and queues expected outputs; a monitor on the
// falling edge pops and compares them against the DUT.
module tb_xpsr_ctrl;

    localparam int unsigned SD = 4;
    localparam int unsigned EW = 9;
    localparam int unsigned DW = $clog2(SD + 1);
    localparam logic [31:0] APSR_MASK = 32'hF800_0000;
    localparam logic [31:0] EPSR_MASK = 32'h0700_FC00;
    localparam logic [31:0] IPSR_MASK = (32'd1 << EW) - 32'd1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [3:0]    flags_in = '0;
    logic          flags_we = 1'b0;
    logic          q_set = 1'b0;
    logic          msr_en = 1'b0;
    logic [31:0]   msr_data = '0;
    logic          it_init_en = 1'b0;
    logic [7:0]    it_init = '0;
    logic          it_advance = 1'b0;
    logic [1:0]    read_addr = '0;
    logic [31:0]   read_data;
    logic          in_it_block;
    logic [3:0]    it_cond;
    logic [DW-1:0] stack_depth;

    xpsr_ctrl_if #(.EXC_NUM_W(EW)) bus ();

    xpsr_ctrl #(.STACK_DEPTH(SD), .EXC_NUM_W(EW)) dut (
        .clk(clk), .rst_n(rst_n), .flags_in(flags_in), .flags_we(flags_we),
        .q_set(q_set), .msr_en(msr_en), .msr_data(msr_data),
        .it_init_en(it_init_en), .it_init(it_init), .it_advance(it_advance),
        .exc(bus.slave), .read_addr(read_addr), .read_data(read_data),
        .in_it_block(in_it_block), .it_cond(it_cond), .stack_depth(stack_depth)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rd;
        logic        er;
        logic        rr;
        int          dep;
        logic        iib;
        logic [3:0]  ic;
        bit          use_c;
        logic [31:0] c;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: the full xPSR word, a queue of saved words, and a
    // pending entry/return that completes one edge after its handshake.
    logic [31:0]   m_word;
    logic [31:0]   m_stack[$];
    int            m_pend;      // 0 none, 1 entry, 2 return
    logic [31:0]   m_saved;
    logic [EW-1:0] m_exc;

    function automatic logic [7:0] it_of(input logic [31:0] w);
        return {w[15:10], w[26:25]};
    endfunction

    function automatic logic [31:0] put_it(input logic [31:0] w, input logic [7:0] it);
        logic [31:0] r;
        r = w & ~32'h0600_FC00;
        r = r | (32'(it >> 2) << 10) | (32'(it & 8'h03) << 25);
        return r;
    endfunction

    function automatic logic [31:0] view(input logic [31:0] w, input logic [1:0] a);
        case (a)
            2'd0:    return w & APSR_MASK;
            2'd1:    return w & IPSR_MASK;
            2'd2:    return w & EPSR_MASK;
            default: return w;
        endcase
    endfunction

    task automatic model_reset();
        m_word = 32'h0100_0000;
        m_stack.delete();
        m_pend = 0;
        m_saved = '0;
        m_exc = '0;
    endtask

    task automatic model_update();
        logic [31:0] w;
        logic [31:0] old;
        logic [7:0]  it;
        bit          ef;
        bit          rf;
        int          sz;
        if (!rst_n) begin
            model_reset();
            return;
        end
        sz  = m_stack.size();
        ef  = bus.exc_entry_valid && m_pend == 0 && sz < int'(SD);
        rf  = bus.exc_return_valid && m_pend == 0 && sz != 0 && !ef;
        old = m_word;
        w   = m_word;
        if (m_pend == 2) begin
            w = m_stack.pop_back();
        end else begin
            if (msr_en)
                w = (w & ~APSR_MASK) | (msr_data & APSR_MASK);
            else if (flags_we)
                w = (w & ~32'hF000_0000) | (32'(flags_in) << 28);
            if (q_set)
                w = w | 32'h0800_0000;
            it = it_of(w);
            if (it_init_en)
                it = it_init;
            else if (it_advance && it != 0)
                it = ((it & 8'h07) == 0) ? 8'h00 : ((it & 8'hE0) | ((it << 1) & 8'h1F));
            w = put_it(w, it);
            if (m_pend == 1) begin
                m_stack.push_back(m_saved);
                w = (w & ~IPSR_MASK) | 32'(m_exc);
                w = put_it(w, 8'h00);
            end
        end
        m_word = w;
        m_pend = ef ? 1 : (rf ? 2 : 0);
        if (ef) begin
            m_saved = old;
            m_exc   = bus.exc_num;
        end
    endtask

    task automatic clr();
        flags_in = '0; flags_we = 0; q_set = 0; msr_en = 0; msr_data = '0;
        it_init_en = 0; it_init = '0; it_advance = 0;
        bus.exc_entry_valid = 0; bus.exc_return_valid = 0; bus.exc_num = '0;
    endtask

    // Queue expectations for the current cycle, then clock once.
    task automatic step(input logic [1:0] addr, input bit use_c, input logic [31:0] c);
        exp_t        e;
        logic [7:0]  it;
        read_addr = addr;
        it      = it_of(m_word);
        e.rd    = view(m_word, addr);
        e.er    = (m_pend == 0) && (m_stack.size() < int'(SD));
        e.rr    = (m_pend == 0) && (m_stack.size() != 0);
        e.dep   = m_stack.size();
        e.iib   = (it & 8'h0F) != 0;
        e.ic    = 4'(it >> 4);
        e.use_c = use_c;
        e.c     = c;
        exp_q.push_back(e);
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%08h required=%08h t=%0t", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("read_data", read_data, e.rd);
            chk("entry_ready", 32'(bus.exc_entry_ready), 32'(e.er));
            chk("return_ready", 32'(bus.exc_return_ready), 32'(e.rr));
            chk("stack_depth", 32'(stack_depth), 32'(e.dep));
            chk("in_it_block", 32'(in_it_block), 32'(e.iib));
            chk("it_cond", 32'(it_cond), 32'(e.ic));
            if (e.use_c)
                chk("directed_view", read_data, e.c);
        end
    end

    initial begin
        logic [31:0] ret_ipsr [4];
        ret_ipsr[0] = 32'd4; ret_ipsr[1] = 32'd3; ret_ipsr[2] = 32'd2; ret_ipsr[3] = 32'd0;
        clr();
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Reset views
        step(2'd0, 1, 32'h0000_0000);
        step(2'd1, 1, 32'h0000_0000);
        step(2'd2, 1, 32'h0100_0000);
        step(2'd3, 1, 32'h0100_0000);

        // Flags, sticky Q, MSR priority
        clr(); flags_in = 4'hA; flags_we = 1; q_set = 1; step(2'd0, 0, 0);
        clr(); flags_in = 4'h4; flags_we = 1;            step(2'd0, 1, 32'hA800_0000);
        clr(); msr_en = 1; msr_data = 32'h0; flags_in = 4'hF; flags_we = 1;
                                                         step(2'd0, 1, 32'h4800_0000);
        clr();                                           step(2'd0, 1, 32'h0000_0000);

        // IT block of one instruction
        clr(); it_init_en = 1; it_init = 8'h18;          step(2'd2, 0, 0);
        clr(); it_advance = 1;                           step(2'd2, 1, 32'h0100_1800);
        clr();                                           step(2'd2, 1, 32'h0100_0000);

        // IT block of four instructions
        clr(); it_init_en = 1; it_init = 8'h1F;          step(2'd2, 0, 0);
        clr(); it_advance = 1;                           step(2'd2, 1, 32'h0700_1C00);
        clr(); it_advance = 1;                           step(2'd2, 1, 32'h0500_1C00);
        clr(); it_advance = 1;                           step(2'd2, 1, 32'h0100_1C00);
        clr(); it_advance = 1;                           step(2'd2, 1, 32'h0100_1800);
        clr(); it_advance = 1;                           step(2'd2, 1, 32'h0100_0000);

        // Single exception entry and return
        clr(); flags_in = 4'hF; flags_we = 1; it_init_en = 1; it_init = 8'h18;
                                                         step(2'd0, 0, 0);
        clr(); bus.exc_entry_valid = 1; bus.exc_num = 9'd11;
                                                         step(2'd3, 1, 32'hF100_1800);
        clr(); flags_in = 4'h0; flags_we = 1;            step(2'd1, 1, 32'h0000_0000);
        clr();                                           step(2'd1, 1, 32'h0000_000B);
        clr();                                           step(2'd3, 1, 32'h0100_000B);
        clr(); bus.exc_return_valid = 1;                 step(2'd2, 1, 32'h0100_0000);
        clr(); flags_in = 4'h5; flags_we = 1;            step(2'd0, 1, 32'h0000_0000);
        clr();                                           step(2'd3, 1, 32'hF100_1800);

        // Nest to full depth, stall a fifth request, then unwind
        for (int k = 2; k <= 5; k++) begin
            clr(); bus.exc_entry_valid = 1; bus.exc_num = 9'(k); step(2'd1, 0, 0);
            clr();                                           step(2'd1, 0, 0);
        end
        clr(); bus.exc_entry_valid = 1; bus.exc_num = 9'd6;
        repeat (3) step(2'd1, 1, 32'h0000_0005);
        for (int k = 0; k < 4; k++) begin
            clr(); bus.exc_return_valid = 1; step(2'd1, 0, 0);
            clr();                           step(2'd1, 0, 0);
            clr();                           step(2'd1, 1, ret_ipsr[k]);
        end

        // Reset asserted during ENTER
        clr(); bus.exc_entry_valid = 1; bus.exc_num = 9'd7; step(2'd1, 0, 0);
        clr(); rst_n = 1'b0; model_reset();              step(2'd2, 1, 32'h0100_0000);
        rst_n = 1'b1;                                    step(2'd1, 1, 32'h0000_0000);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            flags_in            = 4'($urandom);
            flags_we            = $urandom_range(0, 99) < 50;
            q_set               = $urandom_range(0, 99) < 10;
            msr_en              = $urandom_range(0, 99) < 10;
            msr_data            = $urandom;
            it_init_en          = $urandom_range(0, 99) < 10;
            it_init             = 8'($urandom);
            it_advance          = $urandom_range(0, 99) < 40;
            bus.exc_entry_valid = $urandom_range(0, 99) < 20;
            bus.exc_return_valid = $urandom_range(0, 99) < 20;
            bus.exc_num         = 9'($urandom);
            step(2'($urandom), 0, 0);
        end
        clr();

        for (int w = 0; w < 10 && exp_q.size() != 0; w++) @(posedge clk);
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
